pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Registered, parametrised control decoder for the ID/EX boundary of the RV32IM(+Zbb) pipeline. Decodes the full instruction word in ID, drives rs-usage flags combinationally to the hazard unit, and presents registered EX-stage control. It also owns two sequencing duties:

- holding EX for multi-cycle M-extension ops;
- draining the pipeline and halting after ECALL/EBREAK.

## Interface

Parameters:
- DATA_WIDTH, 32, datapath width; 32 or 64; byte-enable width BE = DATA_WIDTH/8
- ENABLE_M, 1, 0 makes funct7=0000001 R-type illegal
- MUL_LATENCY, 2, EX occupancy in cycles for MUL* (funct3[2]=0), ≥1
- DIV_LATENCY, 33, EX occupancy in cycles for DIV*/REM* (funct3[2]=1), ≥1
- HALT_DRAIN, 3, bubble cycles after ECALL/EBREAK before halt, ≥1

Ports:
- clk  in  1  clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high
- instr_i  in  32  ID-stage instruction word
- valid_i  in  1  instr_i is a real instruction
- hazard_stall_i  in  1  load-use stall; inject bubble into EX
- flush_i  in  1  branch/jump redirect; kill EX contents
- rs1_in_use_o, rs2_in_use_o  out  1  combinational from instr_i; 0 when valid_i=0
- mem_to_reg_o, rd_we_o, alu_src_b_o, branch_o, pc_operand_o  out  1  registered EX control
- alu_2bit_op_o  out  2  registered EX control
- data_mem_we_o  out  BE  registered store byte enables, base-aligned
- stop_flag_o  out  1  registered; 1 while ECALL/EBREAK occupies EX
- illegal_o  out  1  registered; EX holds an undecodable instruction
- ex_valid_o  out  1  EX instruction advances to MEM at the next edge
- stall_o  out  1  freeze PC and IF/ID
- halted_o  out  1  sticky halt

## Operation

Decode table:

| Instruction | mem_to_reg | rd_we | alu_src_b | branch | alu_op | rs1/rs2 | pc_operand | stop |
|---|---|---|---|---|---|---|---|---|
| R (0110011) | 0 | 1 | 0 | 0 | 10 | 1/1 | 0 | 0 |
| I-ALU (0010011) | 0 | 1 | 1 | 0 | 11 | 1/0 | 0 | 0 |
| LOAD (0000011) | 1 | 1 | 1 | 0 | 00 | 1/0 | 0 | 0 |
| BRANCH (1100011) | 0 | 0 | 1 | 1 | 01 | 1/1 | 0 | 0 |
| STORE (0100011) | 0 | 0 | 1 | 0 | 00 | 1/1 | 0 | 0 |
| JALR (1100111) | 0 | 1 | 1 | 1 | 00 | 1/0 | 1 | 0 |
| JAL (1101111) | 0 | 1 | 1 | 1 | 00 | 0/0 | 0 | 0 |
| AUIPC (0010111) | 0 | 1 | 1 | 0 | 00 | 0/0 | 1 | 0 |
| LUI (0110111) | 0 | 1 | 1 | 0 | 00 | 0/0 | 0 | 0 |
| SYSTEM (1110011) | 0 | 0 | 0 | 0 | 00 | 0/0 | 0 | 1 |

- Store byte enables by funct3:
  - SB (000) = 0x1, SH (001) = 0x3, SW (010) = 0xF, all zero-extended to BE bits.
  - SD (011) = 0xFF, only when DATA_WIDTH=64.
  - Any other funct3 is illegal.
- Illegal cases:
  - unknown opcode;
  - bad store funct3;
  - M-op with ENABLE_M=0.
  - Response: all EX control 0, illegal_o=1, ex_valid_o=1.
- Bubble: all EX control, illegal_o and ex_valid_o are 0.
- EX register load priority in RUN: reset > flush_i (bubble) > hazard_stall_i (bubble) > valid_i=0 (bubble) > decode instr_i.

State machine: RUN, MDU_BUSY, DRAIN, HALTED. A down-counter cnt is wide enough for max(DIV_LATENCY, HALT_DRAIN).
- RUN → MDU_BUSY: a decoded M-op is captured and its latency L > 1. At the same edge, cnt ← L-1.
- RUN → DRAIN: SYSTEM is captured. At the same edge, cnt ← HALT_DRAIN.
- MDU_BUSY:
  - EX register holds; each edge cnt ← cnt-1.
  - At the edge where cnt=1: go to RUN, EX still holds.
  - Total EX occupancy is exactly L cycles.
- DRAIN:
  - First edge: the SYSTEM op leaves EX and is replaced by a bubble.
  - cnt decrements each edge; bubbles are inserted.
  - At cnt=1: go to HALTED.
- HALTED: bubbles only; exit only by reset.
- flush_i:
  - In MDU_BUSY: EX ← bubble, cnt ← 0, go to RUN.
  - In DRAIN and HALTED: ignored.
- hazard_stall_i: ignored outside RUN.

## Timing

- Reset (synchronous, active-high): every registered output 0, state RUN, cnt 0. The first edge with reset=0 may capture instr_i.
- Decode latency: 1 edge, from instr_i to the EX outputs.
- rs*_in_use_o: zero latency.
- stall_o is combinational from state: 1 in MDU_BUSY, DRAIN and HALTED; 0 in RUN.
- ex_valid_o = EX register valid AND state≠MDU_BUSY.
- stop_flag_o is 1 for exactly one cycle per SYSTEM op.
- halted_o rises HALT_DRAIN+1 edges after the SYSTEM capture edge.
- Reset mid-MDU or mid-DRAIN aborts immediately to the reset values.

## Test plan

- reset=1 for 2 cycles with instr_i=ADD → all outputs 0, stall_o=0.
- Stream ADD, LW, SW, BEQ, JALR, LUI with valid_i=1 → each cycle's EX outputs match the decode table. SW gives data_mem_we_o=0x0F (DATA_WIDTH=32).
- MUL then DIV, defaults → stall_o=1 for 1 cycle after MUL and 32 cycles after DIV. ex_valid_o=1 only on the final occupancy cycle of each.
- DIV captured, flush_i=1 three cycles later → next edge gives EX bubble, state RUN, stall_o=0.
- ECALL, HALT_DRAIN=3 → stop_flag_o=1 for one cycle, stall_o=1 from the next cycle, halted_o=1 four edges after capture. flush_i pulses have no effect. reset clears halted_o.
- DATA_WIDTH=64 SD → data_mem_we_o=0xFF. DATA_WIDTH=32 SD → illegal_o=1. ENABLE_M=0 MUL → illegal_o=1 and no stall.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// ID/EX control decoder for the RV32IM(+Zbb) pipeline: registered EX control,
// combinational rs-usage flags, multi-cycle M-op hold and ECALL/EBREAK drain-and-halt.
module pipelined_control_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ENABLE_M    = 1,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 33,
    parameter int HALT_DRAIN  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instr_i,
    input  logic                    valid_i,
    input  logic                    hazard_stall_i,
    input  logic                    flush_i,
    output logic                    rs1_in_use_o,
    output logic                    rs2_in_use_o,
    output logic                    mem_to_reg_o,
    output logic                    rd_we_o,
    output logic                    alu_src_b_o,
    output logic                    branch_o,
    output logic                    pc_operand_o,
    output logic [1:0]              alu_2bit_op_o,
    output logic [DATA_WIDTH/8-1:0] data_mem_we_o,
    output logic                    stop_flag_o,
    output logic                    illegal_o,
    output logic                    ex_valid_o,
    output logic                    stall_o,
    output logic                    halted_o
);
    localparam int BE      = DATA_WIDTH / 8;
    localparam int MAX_ML  = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int MAX_CNT = (MAX_ML > HALT_DRAIN) ? MAX_ML : HALT_DRAIN;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] MUL_RELOAD = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_RELOAD = CW'(DIV_LATENCY - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(HALT_DRAIN);
    localparam logic          MUL_MULTI  = (MUL_LATENCY > 1);
    localparam logic          DIV_MULTI  = (DIV_LATENCY > 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {RUN, MDU_BUSY, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic          memToReg;
        logic          rdWe;
        logic          aluSrcB;
        logic          branch;
        logic          pcOperand;
        logic [1:0]    aluOp;
        logic [BE-1:0] memWe;
        logic          stop;
        logic          illegal;
        logic          valid;
    } exCtrl_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    exCtrl_t       exCtrl_q;
    logic          halted_q;

    exCtrl_t       decCtrl_d;
    logic          isMop_d;
    logic          rs1Use_d;
    logic          rs2Use_d;
    logic          mopMulti_d;
    logic [CW-1:0] mopReload_d;

    always_comb begin
        decCtrl_d       = '0;
        decCtrl_d.valid = 1'b1;
        isMop_d         = 1'b0;
        rs1Use_d        = 1'b0;
        rs2Use_d        = 1'b0;
        case (instr_i[6:0])
            OP_R: begin
                decCtrl_d.rdWe  = 1'b1;
                decCtrl_d.aluOp = 2'b10;
                rs1Use_d        = 1'b1;
                rs2Use_d        = 1'b1;
                if (instr_i[31:25] == 7'b0000001) begin
                    if (ENABLE_M != 0) isMop_d = 1'b1;
                    else               decCtrl_d.illegal = 1'b1;
                end
            end
            OP_IALU: begin
                decCtrl_d.rdWe    = 1'b1;
                decCtrl_d.aluSrcB = 1'b1;
                decCtrl_d.aluOp   = 2'b11;
                rs1Use_d          = 1'b1;
            end
            OP_LOAD: begin
                decCtrl_d.memToReg = 1'b1;
                decCtrl_d.rdWe     = 1'b1;
                decCtrl_d.aluSrcB  = 1'b1;
                rs1Use_d           = 1'b1;
            end
            OP_BRANCH: begin
                decCtrl_d.aluSrcB = 1'b1;
                decCtrl_d.branch  = 1'b1;
                decCtrl_d.aluOp   = 2'b01;
                rs1Use_d          = 1'b1;
                rs2Use_d          = 1'b1;
            end
            OP_STORE: begin
                decCtrl_d.aluSrcB = 1'b1;
                rs1Use_d          = 1'b1;
                rs2Use_d          = 1'b1;
                case (instr_i[14:12])
                    3'b000:  decCtrl_d.memWe = BE'(1'b1);
                    3'b001:  decCtrl_d.memWe = BE'(2'b11);
                    3'b010:  decCtrl_d.memWe = BE'(4'hF);
                    3'b011: begin
                        if (DATA_WIDTH == 64) decCtrl_d.memWe = '1;
                        else                  decCtrl_d.illegal = 1'b1;
                    end
                    default: decCtrl_d.illegal = 1'b1;
                endcase
            end
            OP_JALR: begin
                decCtrl_d.rdWe      = 1'b1;
                decCtrl_d.aluSrcB   = 1'b1;
                decCtrl_d.branch    = 1'b1;
                decCtrl_d.pcOperand = 1'b1;
                rs1Use_d            = 1'b1;
            end
            OP_JAL: begin
                decCtrl_d.rdWe    = 1'b1;
                decCtrl_d.aluSrcB = 1'b1;
                decCtrl_d.branch  = 1'b1;
            end
            OP_AUIPC: begin
                decCtrl_d.rdWe      = 1'b1;
                decCtrl_d.aluSrcB   = 1'b1;
                decCtrl_d.pcOperand = 1'b1;
            end
            OP_LUI: begin
                decCtrl_d.rdWe    = 1'b1;
                decCtrl_d.aluSrcB = 1'b1;
            end
            OP_SYSTEM: decCtrl_d.stop = 1'b1;
            default:   decCtrl_d.illegal = 1'b1;
        endcase
        // An undecodable word still travels to EX as a valid slot so the trap logic sees it.
        if (decCtrl_d.illegal) begin
            decCtrl_d         = '0;
            decCtrl_d.illegal = 1'b1;
            decCtrl_d.valid   = 1'b1;
        end
    end

    assign mopMulti_d   = instr_i[14] ? DIV_MULTI  : MUL_MULTI;
    assign mopReload_d  = instr_i[14] ? DIV_RELOAD : MUL_RELOAD;
    assign rs1_in_use_o = valid_i & rs1Use_d;
    assign rs2_in_use_o = valid_i & rs2Use_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            exCtrl_q <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (flush_i || hazard_stall_i || !valid_i) begin
                        exCtrl_q <= '0;
                    end else begin
                        exCtrl_q <= decCtrl_d;
                        if (decCtrl_d.stop) begin
                            state_q <= DRAIN;
                            cnt_q   <= DRAIN_LOAD;
                        end else if (isMop_d && mopMulti_d) begin
                            state_q <= MDU_BUSY;
                            cnt_q   <= mopReload_d;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (flush_i) begin
                        exCtrl_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_q <= RUN;
                    end
                end
                DRAIN: begin
                    exCtrl_q <= '0;
                    cnt_q    <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_q <= HALTED;
                end
                default: begin
                    exCtrl_q <= '0;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_to_reg_o  = exCtrl_q.memToReg;
    assign rd_we_o       = exCtrl_q.rdWe;
    assign alu_src_b_o   = exCtrl_q.aluSrcB;
    assign branch_o      = exCtrl_q.branch;
    assign pc_operand_o  = exCtrl_q.pcOperand;
    assign alu_2bit_op_o = exCtrl_q.aluOp;
    assign data_mem_we_o = exCtrl_q.memWe;
    assign stop_flag_o   = exCtrl_q.stop;
    assign illegal_o     = exCtrl_q.illegal;
    assign ex_valid_o    = exCtrl_q.valid && (state_q != MDU_BUSY);
    assign stall_o       = (state_q != RUN);
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode table, M-op hold, flush, drain/halt,
// and the DATA_WIDTH=64 / ENABLE_M=0 variants.
module tb_pipelined_control_unit;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_SW    = 32'h0050A023;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_BADST = 32'h0050D023;
    localparam logic [31:0] I_SD    = 32'h0050B023;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_DIV   = 32'h023140B3;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    // {mem_to_reg, rd_we, alu_src_b, branch, pc_operand, alu_op, we[3:0], stop, illegal, ex_valid}
    localparam logic [13:0] E_ADD     = 14'b01000_10_0000_001;
    localparam logic [13:0] E_MDU_HLD = 14'b01000_10_0000_000;
    localparam logic [13:0] E_ECALL   = 14'b00000_00_0000_101;
    localparam logic [13:0] E_ILL     = 14'b00000_00_0000_011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] instr = '0;
    logic valid = 1'b0;
    logic hazard = 1'b0;
    logic flush = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    logic m_rs1, m_rs2, m_memToReg, m_rdWe, m_aluSrcB, m_branch, m_pcOperand;
    logic [1:0] m_aluOp;
    logic [3:0] m_memWe;
    logic m_stop, m_illegal, m_exValid, m_stall, m_halted;

    logic w_rs1, w_rs2, w_memToReg, w_rdWe, w_aluSrcB, w_branch, w_pcOperand;
    logic [1:0] w_aluOp;
    logic [7:0] w_memWe;
    logic w_stop, w_illegal, w_exValid, w_stall, w_halted;

    logic n_rs1, n_rs2, n_memToReg, n_rdWe, n_aluSrcB, n_branch, n_pcOperand;
    logic [1:0] n_aluOp;
    logic [3:0] n_memWe;
    logic n_stop, n_illegal, n_exValid, n_stall, n_halted;

    logic [13:0] exBus;
    assign exBus = {m_memToReg, m_rdWe, m_aluSrcB, m_branch, m_pcOperand, m_aluOp,
                    m_memWe, m_stop, m_illegal, m_exValid};

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .reset(reset), .instr_i(instr), .valid_i(valid),
        .hazard_stall_i(hazard), .flush_i(flush),
        .rs1_in_use_o(m_rs1), .rs2_in_use_o(m_rs2), .mem_to_reg_o(m_memToReg),
        .rd_we_o(m_rdWe), .alu_src_b_o(m_aluSrcB), .branch_o(m_branch),
        .pc_operand_o(m_pcOperand), .alu_2bit_op_o(m_aluOp), .data_mem_we_o(m_memWe),
        .stop_flag_o(m_stop), .illegal_o(m_illegal), .ex_valid_o(m_exValid),
        .stall_o(m_stall), .halted_o(m_halted)
    );

    pipelined_control_unit #(.DATA_WIDTH(64)) dutWide (
        .clk(clk), .reset(reset), .instr_i(instr), .valid_i(valid),
        .hazard_stall_i(hazard), .flush_i(flush),
        .rs1_in_use_o(w_rs1), .rs2_in_use_o(w_rs2), .mem_to_reg_o(w_memToReg),
        .rd_we_o(w_rdWe), .alu_src_b_o(w_aluSrcB), .branch_o(w_branch),
        .pc_operand_o(w_pcOperand), .alu_2bit_op_o(w_aluOp), .data_mem_we_o(w_memWe),
        .stop_flag_o(w_stop), .illegal_o(w_illegal), .ex_valid_o(w_exValid),
        .stall_o(w_stall), .halted_o(w_halted)
    );

    pipelined_control_unit #(.ENABLE_M(0)) dutNoM (
        .clk(clk), .reset(reset), .instr_i(instr), .valid_i(valid),
        .hazard_stall_i(hazard), .flush_i(flush),
        .rs1_in_use_o(n_rs1), .rs2_in_use_o(n_rs2), .mem_to_reg_o(n_memToReg),
        .rd_we_o(n_rdWe), .alu_src_b_o(n_aluSrcB), .branch_o(n_branch),
        .pc_operand_o(n_pcOperand), .alu_2bit_op_o(n_aluOp), .data_mem_we_o(n_memWe),
        .stop_flag_o(n_stop), .illegal_o(n_illegal), .ex_valid_o(n_exValid),
        .stall_o(n_stall), .halted_o(n_halted)
    );

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic hz, input logic fl);
        instr  = ins;
        valid  = v;
        hazard = hz;
        flush  = fl;
        #1;
    endtask

    task automatic doReset();
        applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        testsRun++;
        if (exBus !== 14'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ex: got %b expected %b", exBus, 14'h0);
        end
        testsRun++;
        if ({m_stall, m_halted} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_stall_halt: got %b expected 00", {m_stall, m_halted});
        end
        reset = 1'b0;
    endtask

    task automatic test_decode_stream();
        logic [31:0] ins [12] = '{I_ADD, I_LW, I_SW, I_BEQ, I_JALR, I_LUI, I_ADDI, I_JAL,
                                  I_BAD, I_BADST, I_ADD, I_ADD};
        logic        vld [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic        hzd [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [1:0]  rsE [12] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00,
                                  2'b00, 2'b11, 2'b11, 2'b00};
        logic [13:0] exE [12] = '{E_ADD,
                                  14'b11100_00_0000_001,
                                  14'b00100_00_1111_001,
                                  14'b00110_01_0000_001,
                                  14'b01111_00_0000_001,
                                  14'b01100_00_0000_001,
                                  14'b01100_11_0000_001,
                                  14'b01110_00_0000_001,
                                  E_ILL, E_ILL, 14'h0, 14'h0};
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(ins[i], vld[i], hzd[i], 1'b0);
            testsRun++;
            if ({m_rs1, m_rs2} !== rsE[i]) begin
                testsFailed++;
                $display("[TB] FAIL rs_use[%0d]: got %b expected %b", i, {m_rs1, m_rs2}, rsE[i]);
            end
            tick();
            testsRun++;
            if (exBus !== exE[i] || m_stall !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL decode[%0d]: got ex=%b stall=%b expected ex=%b stall=0",
                         i, exBus, m_stall, exE[i]);
            end
        end
    endtask

    task automatic test_mdu_hold();
        int busy = 0;
        int evBad = 0;
        doReset();
        applyStimulus(I_MUL, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(I_DIV, 1'b1, 1'b0, 1'b0);
        testsRun++;
        if (exBus !== E_MDU_HLD || m_stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mul_busy: got ex=%b stall=%b expected ex=%b stall=1", exBus, m_stall, E_MDU_HLD);
        end
        tick();
        testsRun++;
        if (exBus !== E_ADD || m_stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mul_final: got ex=%b stall=%b expected ex=%b stall=0", exBus, m_stall, E_ADD);
        end
        tick();
        applyStimulus(I_DIV, 1'b0, 1'b0, 1'b0);
        while (m_stall === 1'b1 && busy < 40) begin
            if (m_exValid !== 1'b0) evBad++;
            busy++;
            tick();
        end
        testsRun++;
        if (busy != 32) begin
            testsFailed++;
            $display("[TB] FAIL div_stall_cycles: got %0d expected 32", busy);
        end
        testsRun++;
        if (evBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL div_ex_valid_masked: got %0d cycles with ex_valid=1 expected 0", evBad);
        end
        testsRun++;
        if (exBus !== E_ADD) begin
            testsFailed++;
            $display("[TB] FAIL div_final: got %b expected %b", exBus, E_ADD);
        end
        tick();
        testsRun++;
        if (exBus !== 14'h0) begin
            testsFailed++;
            $display("[TB] FAIL div_after_bubble: got %b expected 0", exBus);
        end
    endtask

    task automatic test_flush_mdu();
        doReset();
        applyStimulus(I_DIV, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b1);
        tick();
        testsRun++;
        if (exBus !== 14'h0 || m_stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_mdu: got ex=%b stall=%b expected ex=0 stall=0", exBus, m_stall);
        end
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        testsRun++;
        if (exBus !== E_ADD) begin
            testsFailed++;
            $display("[TB] FAIL flush_resume: got %b expected %b", exBus, E_ADD);
        end
    endtask

    task automatic test_halt();
        doReset();
        applyStimulus(I_ECALL, 1'b1, 1'b0, 1'b0);
        tick();
        testsRun++;
        if (exBus !== E_ECALL || m_stall !== 1'b1 || m_halted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ecall_capture: got ex=%b stall=%b halted=%b expected ex=%b stall=1 halted=0",
                     exBus, m_stall, m_halted, E_ECALL);
        end
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            testsRun++;
            if (exBus !== 14'h0 || m_stall !== 1'b1 || m_halted !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL drain[%0d]: got ex=%b stall=%b halted=%b expected ex=0 stall=1 halted=0",
                         i, exBus, m_stall, m_halted);
            end
        end
        tick();
        testsRun++;
        if (m_halted !== 1'b1 || exBus !== 14'h0) begin
            testsFailed++;
            $display("[TB] FAIL halt_rise: got halted=%b ex=%b expected halted=1 ex=0", m_halted, exBus);
        end
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        testsRun++;
        if (m_halted !== 1'b1 || m_stall !== 1'b1 || exBus !== 14'h0) begin
            testsFailed++;
            $display("[TB] FAIL halt_sticky: got halted=%b stall=%b ex=%b expected 1 1 0", m_halted, m_stall, exBus);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        testsRun++;
        if (m_halted !== 1'b0 || m_stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_reset: got halted=%b stall=%b expected 0 0", m_halted, m_stall);
        end
    endtask

    task automatic test_variants();
        doReset();
        applyStimulus(I_SD, 1'b1, 1'b0, 1'b0);
        tick();
        testsRun++;
        if (w_memWe !== 8'hFF || w_illegal !== 1'b0 || w_exValid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sd_wide: got we=%h illegal=%b valid=%b expected ff 0 1", w_memWe, w_illegal, w_exValid);
        end
        testsRun++;
        if (exBus !== E_ILL) begin
            testsFailed++;
            $display("[TB] FAIL sd_narrow: got %b expected %b", exBus, E_ILL);
        end
        doReset();
        applyStimulus(I_MUL, 1'b1, 1'b0, 1'b0);
        tick();
        testsRun++;
        if (n_illegal !== 1'b1 || n_stall !== 1'b0 || n_rdWe !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mul_no_m: got illegal=%b stall=%b rd_we=%b expected 1 0 0", n_illegal, n_stall, n_rdWe);
        end
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        testsRun++;
        if (n_stall !== 1'b0 || n_rdWe !== 1'b1 || n_illegal !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mul_no_m_next: got stall=%b rd_we=%b illegal=%b expected 0 1 0", n_stall, n_rdWe, n_illegal);
        end
    endtask

    initial begin
        test_reset();
        test_decode_stream();
        test_mdu_hold();
        test_flush_mdu();
        test_halt();
        test_variants();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
